fsm_3bit_detector: RTL and testbench
====================================

Name: fsm_3bit_detector

Overview:
- Moore-type serial sequence detector. Samples the 1-bit input `signal` on every rising clock edge.
- Asserts `led` for exactly one clock when the last three sampled bits equal a 3-bit pattern (default 3'b101).
- Used as a small control or indicator block: `signal` comes from upstream logic already synchronous to `clk`, and `led` drives a status LED or a flag consumer.

Parameters:
- PATTERN, 3'b101: target sequence, MSB is the first bit received, LSB the last.
- OVERLAP, 1: 1 = overlapping detection (the tail of one match can start the next); 0 = after a match, detection restarts from scratch.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- signal  input  1  serial data bit, sampled every rising edge of clk
- led  output  1  detect flag, registered Moore output, high for one cycle per match

Behaviour:
- Reset: when rst=1 at a rising edge, state becomes S0 and led becomes 0. rst has priority over signal. A match in progress is discarded when reset occurs mid-sequence.
- Sampling: one bit is consumed per clock while rst=0. There is no enable and no edge qualification. A level held for N clocks counts as N identical bits.
- State encoding, 2-bit state register. The state is the length of the longest received suffix that equals a prefix of PATTERN:
  - S0 = nothing matched
  - S1 = PATTERN[2] matched
  - S2 = PATTERN[2:1] matched
  - S3 = full match
- Transitions are computed per PATTERN using a prefix/suffix (KMP) rule and are fixed at elaboration. For the default 101:
  - S0: 1→S1, 0→S0
  - S1: 0→S2, 1→S1
  - S2: 1→S3, 0→S0
  - S3 with OVERLAP=1: 0→S2, 1→S1
  - S3 with OVERLAP=0: 1→S1, 0→S0
- Output: led = (state == S3), driven from a register. The match therefore appears in the cycle after the edge that sampled the third bit; latency is 1 clock from the last pattern bit.
- led is never high for two consecutive cycles when PATTERN has no self-overlap of length 3. Two consecutive cycles are possible for 3'b000 and 3'b111 with OVERLAP=1, for example a run of four 1s for 111 gives led high on the 3rd and 4th bits.
- X on signal while rst=1 has no effect. After reset the state is always one of S0–S3; no illegal states are reachable, and the default branch returns to S0.

Optional Feature:
- Macro FSM_3BIT_DET_COUNT_EN.
- When defined:
  - Adds output port `det_count`, 8 bits, counting the cycles in which led=1.
  - Clears to 0 on rst.
  - Saturates at 8'hFF and does not wrap.
  - Updates in the same edge that sets led, so it equals the number of matches visible so far.
- When undefined: the port and the counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package fsm_3bit_pkg:
  - state typedef (S0..S3, 2-bit enum)
  - default PATTERN constant
  - a constant function that computes the next-state table from PATTERN and OVERLAP
- Single module, no sub-module. The optional counter is small enough to stay inline.

Test Plan:
- Reset: hold rst=1 for 3 clocks with signal=X → led=0 and state=S0; release rst → led stays 0 while signal=0.
- Basic match: bits 1,0,1 on three consecutive clocks → led=1 for exactly the one cycle after the 3rd edge, then 0 on the next 0 bit.
- Overlap: bits 1,0,1,0,1 with OVERLAP=1 → led pulses twice, after bit 3 and after bit 5. The same stream with OVERLAP=0 → a single pulse after bit 3.
- No false match: bits 1,1,0,0,1,1,1,0 → led stays 0 throughout. Held levels spanning multiple clocks do not produce 101.
- Mid-sequence reset: bits 1,0, then rst=1 for one clock, then 1 → no pulse. Then 0,1 → pulse.
- With FSM_3BIT_DET_COUNT_EN: feed 1,0,1,0,1,0,1 → det_count=3. Feed 300 matches → det_count saturates at 255. rst → det_count=0.

Source files
------------

// File: rtl/fsm_3bit_pkg.sv
// Shared types and constants for the 3-bit serial sequence detector.
// Next-state table is derived from the pattern with a prefix/suffix rule.
package fsm_3bit_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

    localparam logic [2:0] DEFAULT_PATTERN = 3'b101;

    // Entry index is {state, input_bit}.
    typedef logic [7:0][1:0] next_tab_t;

    // Longest suffix of (matched prefix + new bit) that is a pattern prefix.
    function automatic logic [1:0] kmp_next(
        input logic [2:0] pat,
        input logic       ovl,
        input int         s,
        input logic       b
    );
        logic [3:0] seq;
        logic [1:0] best;
        logic       ok;
        int         len;
        seq  = '0;
        best = 2'd0;
        if (s == 3 && !ovl) begin
            return (b == pat[2]) ? 2'd1 : 2'd0;
        end
        for (int j = 0; j < 3; j++) begin
            if (j < s) seq[j] = pat[2-j];
        end
        seq[s] = b;
        len    = s + 1;
        for (int k = 1; k <= 3; k++) begin
            if (k <= len) begin
                ok = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (i < k && seq[len-k+i] != pat[2-i]) ok = 1'b0;
                end
                if (ok) best = 2'(k);
            end
        end
        return best;
    endfunction

    function automatic next_tab_t next_table(
        input logic [2:0] pat,
        input logic       ovl
    );
        next_tab_t t;
        t = '0;
        for (int s = 0; s < 4; s++) begin
            t[2*s]   = kmp_next(pat, ovl, s, 1'b0);
            t[2*s+1] = kmp_next(pat, ovl, s, 1'b1);
        end
        return t;
    endfunction

endpackage

// File: rtl/fsm_3bit_detector.sv
// Moore detector for a 3-bit serial pattern; led pulses one cycle per match.
// Define FSM_3BIT_DET_COUNT_EN to add the saturating det_count match counter.
module fsm_3bit_detector
    import fsm_3bit_pkg::*;
#(
    parameter logic [2:0] PATTERN = DEFAULT_PATTERN,
    parameter bit         OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       signal,
    output logic       led
`ifdef FSM_3BIT_DET_COUNT_EN
    ,
    output logic [7:0] det_count
`endif
);

    localparam next_tab_t NEXT = next_table(PATTERN, OVERLAP);

    state_e state_q, state_d;
    logic   led_q, led_d;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0, S1, S2, S3: state_d = state_e'(NEXT[{state_q, signal}]);
            default:        state_d = S0;
        endcase
        // led is registered from the next state so it aligns with S3
        led_d = (state_d == S3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

`ifdef FSM_3BIT_DET_COUNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (led_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    assign det_count = cnt_q;
`endif

endmodule

// File: tb/tb_fsm_3bit_detector.sv
// Scoreboard bench for fsm_3bit_detector, overlapping and non-overlapping.
// Build with FSM_3BIT_DET_COUNT_EN to also cover det_count.
module tb_fsm_3bit_detector;

    localparam logic [2:0] PAT = 3'b101;

    logic clk;
    logic rst;
    logic signal;
    logic led1;
    logic led0;
    logic [7:0] cnt1;
    logic [7:0] cnt0;

`ifdef FSM_3BIT_DET_COUNT_EN
    fsm_3bit_detector #(.PATTERN(PAT), .OVERLAP(1'b1)) dut (
        .clk(clk), .rst(rst), .signal(signal), .led(led1),
        .det_count(cnt1)
    );
    fsm_3bit_detector #(.PATTERN(PAT), .OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .signal(signal), .led(led0),
        .det_count(cnt0)
    );
`else
    fsm_3bit_detector #(.PATTERN(PAT), .OVERLAP(1'b1)) dut (
        .clk(clk), .rst(rst), .signal(signal), .led(led1)
    );
    fsm_3bit_detector #(.PATTERN(PAT), .OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .signal(signal), .led(led0)
    );
    assign cnt1 = 8'd0;
    assign cnt0 = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       l1;
        logic       l0;
        logic [7:0] c1;
        logic [7:0] c0;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw bit history plus bits seen since restart
    logic [2:0] m_hist = 3'b000;
    int         m_n1   = 0;
    int         m_n0   = 0;
    logic [7:0] m_c1   = 8'd0;
    logic [7:0] m_c0   = 8'd0;

    task automatic step(input logic r, input logic b,
                        output logic o1, output logic o0);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst    = r;
        signal = b;
        if (r) begin
            m_n1 = 0;
            m_n0 = 0;
            m_c1 = 8'd0;
            m_c0 = 8'd0;
            e    = '0;
        end else begin
            m_hist = {m_hist[1:0], b};
            if (m_n1 < 3) m_n1++;
            if (m_n0 < 3) m_n0++;
            e.l1 = (m_n1 == 3 && m_hist == PAT);
            e.l0 = (m_n0 == 3 && m_hist == PAT);
            if (e.l0) m_n0 = 0;
            if (e.l1 && m_c1 != 8'hFF) m_c1++;
            if (e.l0 && m_c0 != 8'hFF) m_c0++;
            e.c1 = m_c1;
            e.c0 = m_c0;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        o1 = led1;
        o0 = led0;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got=%0d want=1", q.size());
        end else begin
            got = q.pop_front();
            if (led1 !== got.l1) begin
                n_fail++;
                $display("FAIL led_ovl got=%b want=%b t=%0t", led1, got.l1, $time);
            end
            n_checks++;
            if (led0 !== got.l0) begin
                n_fail++;
                $display("FAIL led_noovl got=%b want=%b t=%0t", led0, got.l0, $time);
            end
`ifdef FSM_3BIT_DET_COUNT_EN
            n_checks++;
            if (cnt1 !== got.c1) begin
                n_fail++;
                $display("FAIL cnt_ovl got=%0d want=%0d t=%0t", cnt1, got.c1, $time);
            end
            n_checks++;
            if (cnt0 !== got.c0) begin
                n_fail++;
                $display("FAIL cnt_noovl got=%0d want=%0d t=%0t", cnt0, got.c0, $time);
            end
`endif
        end
    endtask

    task automatic test_reset();
        logic a, b;
        for (int i = 0; i < 3; i++) step(1'b1, 1'bx, a, b);
        n_checks++;
        if (dut.state_q !== 2'd0 || dut_no.state_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%0d/%0d want=0/0",
                     dut.state_q, dut_no.state_q);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, a, b);
    endtask

    task automatic test_basic();
        logic a, b;
        int p;
        p = 0;
        step(1'b0, 1'b1, a, b);
        step(1'b0, 1'b0, a, b);
        step(1'b0, 1'b1, a, b);
        p += int'(a);
        step(1'b0, 1'b0, a, b);
        p += int'(a);
        n_checks++;
        if (p !== 1) begin
            n_fail++;
            $display("FAIL basic_pulses got=%0d want=1", p);
        end
    endtask

    task automatic test_overlap();
        logic a, b;
        int p1, p0;
        logic [4:0] bits;
        p1 = 0;
        p0 = 0;
        bits = 5'b10101;
        step(1'b1, 1'b0, a, b);
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, bits[i], a, b);
            p1 += int'(a);
            p0 += int'(b);
        end
        n_checks++;
        if (p1 !== 2) begin
            n_fail++;
            $display("FAIL overlap_pulses got=%0d want=2", p1);
        end
        n_checks++;
        if (p0 !== 1) begin
            n_fail++;
            $display("FAIL nooverlap_pulses got=%0d want=1", p0);
        end
    endtask

    task automatic test_no_false();
        logic a, b;
        int p;
        logic [7:0] bits;
        p = 0;
        bits = 8'b11001110;
        step(1'b1, 1'b0, a, b);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, bits[i], a, b);
            p += int'(a) + int'(b);
        end
        n_checks++;
        if (p !== 0) begin
            n_fail++;
            $display("FAIL no_false_pulses got=%0d want=0", p);
        end
    endtask

    task automatic test_mid_reset();
        logic a, b;
        int p;
        p = 0;
        step(1'b1, 1'b0, a, b);
        step(1'b0, 1'b1, a, b);
        step(1'b0, 1'b0, a, b);
        step(1'b1, 1'b1, a, b);
        step(1'b0, 1'b1, a, b);
        p += int'(a) + int'(b);
        n_checks++;
        if (p !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_early got=%0d want=0", p);
        end
        step(1'b0, 1'b0, a, b);
        step(1'b0, 1'b1, a, b);
        n_checks++;
        if (a !== 1'b1 || b !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_late got=%b%b want=11", a, b);
        end
    endtask

    task automatic test_back_to_back();
        logic a, b;
        step(1'b1, 1'b0, a, b);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), a, b);
        end
    endtask

`ifdef FSM_3BIT_DET_COUNT_EN
    task automatic test_count();
        logic a, b;
        logic [6:0] bits;
        bits = 7'b1010101;
        step(1'b1, 1'b0, a, b);
        for (int i = 6; i >= 0; i--) step(1'b0, bits[i], a, b);
        n_checks++;
        if (cnt1 !== 8'd3) begin
            n_fail++;
            $display("FAIL count_three got=%0d want=3", cnt1);
        end
        step(1'b1, 1'b0, a, b);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, a, b);
            step(1'b0, 1'b0, a, b);
            step(1'b0, 1'b1, a, b);
        end
        n_checks++;
        if (cnt1 !== 8'hFF || cnt0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL count_sat got=%0d/%0d want=255/255", cnt1, cnt0);
        end
        step(1'b1, 1'b0, a, b);
        n_checks++;
        if (cnt1 !== 8'd0 || cnt0 !== 8'd0) begin
            n_fail++;
            $display("FAIL count_clear got=%0d/%0d want=0/0", cnt1, cnt0);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        signal = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_no_false();
        test_mid_reset();
        test_back_to_back();
`ifdef FSM_3BIT_DET_COUNT_EN
        test_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
